// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback source handshakes and regfile write port
interface rf_wb_arbiter_if #(parameter int XLEN = 32);
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, rf_we, rf_rd, rf_wd
  );
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, rf_we, rf_rd, rf_wd
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regfile write port between ALU and mul/div writeback with a pending-rd scoreboard
module rf_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_wb_arbiter_if.slave     bus,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic [4:0]         chk_rs1,
  input  logic [4:0]         chk_rs2,
  input  logic [4:0]         chk_rd,
  output logic               hazard,
  output logic [31:0]        busy_mask,
  output logic               err
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0]   starve_cnt;
  logic            b_win, a_xfer, b_xfer, xfer, err_now;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [31:0]     set_vec, clr_vec;
  assign b_win       = starve_cnt == CW'(STARVE_LIMIT);
  assign bus.a_ready = !b_win || !bus.b_valid;
  assign bus.b_ready = b_win || !bus.a_valid;
  always_comb begin
    a_xfer  = bus.a_valid && bus.a_ready;
    b_xfer  = bus.b_valid && bus.b_ready && !a_xfer;
    xfer    = a_xfer || b_xfer;
    wr_rd   = a_xfer ? bus.a_rd : bus.b_rd;
    wr_data = a_xfer ? bus.a_data : bus.b_data;
    set_vec = issue_valid ? 32'b1 << issue_rd : '0;
    clr_vec = b_xfer ? 32'b1 << bus.b_rd : '0;
    hazard  = busy_mask[chk_rs1] | busy_mask[chk_rs2] | busy_mask[chk_rd];
    err_now = (issue_valid && issue_rd != 5'd0 && busy_mask[issue_rd] && !clr_vec[issue_rd])
           || (b_xfer && !busy_mask[bus.b_rd])
           || (a_xfer && busy_mask[bus.a_rd]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we  <= 1'b0;
      bus.rf_rd  <= '0;
      bus.rf_wd  <= '0;
      starve_cnt <= '0;
      busy_mask  <= '0;
      err        <= 1'b0;
    end else begin
      bus.rf_we <= xfer && wr_rd != 5'd0;
      if (xfer) begin
        bus.rf_rd <= wr_rd;
        bus.rf_wd <= wr_data;
      end
      starve_cnt <= (!bus.b_valid || b_xfer) ? '0 : (b_win ? starve_cnt : starve_cnt + 1'b1);
      busy_mask  <= ((busy_mask & ~clr_vec) | set_vec) & ~32'b1;
      err        <= err | err_now;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of grant, write port, scoreboard, errors and async reset
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic issue_valid;
  logic [4:0] issue_rd, chk_rs1, chk_rs2, chk_rd;
  logic hazard, err;
  logic [31:0] busy_mask;
  int total = 0;
  int bad = 0;
  rf_wb_arbiter_if #(.XLEN(32)) bus();
  rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .busy_mask(busy_mask), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    issue_valid = 0; issue_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask
  task automatic do_reset;
    rst_n = 0;
    #1;
    rst_n = 1;
    tick();
  endtask
  task automatic test_reset;
    idle();
    rst_n = 0;
    #2;
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", bus.rf_we); end
    total++; if (bus.rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rf_rd got=%0d exp=0", bus.rf_rd); end
    total++; if (bus.rf_wd !== 32'd0) begin bad++; $display("FAIL reset_rf_wd got=%h exp=0", bus.rf_wd); end
    total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1;
    tick();
  endtask
  task automatic test_a_only;
    bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'h11;
    #1;
    total++; if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL a_only_ready got=%b exp=1", bus.a_ready); end
    tick();
    idle();
    total++; if ({bus.rf_we, bus.rf_rd, bus.rf_wd} !== {1'b1, 5'd3, 32'h11})
      begin bad++; $display("FAIL a_only_write got=%b/%0d/%h exp=1/3/11", bus.rf_we, bus.rf_rd, bus.rf_wd); end
    tick();
    total++; if ({bus.rf_we, bus.rf_rd} !== {1'b0, 5'd3})
      begin bad++; $display("FAIL a_only_hold got=%b/%0d exp=0/3", bus.rf_we, bus.rf_rd); end
  endtask
  task automatic test_contention;
    issue_valid = 1; issue_rd = 5;
    tick();
    idle();
    bus.a_valid = 1; bus.a_rd = 2; bus.a_data = 32'hA;
    bus.b_valid = 1; bus.b_rd = 5; bus.b_data = 32'hB;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if ({bus.a_ready, bus.b_ready} !== {i != 4, i == 4})
        begin bad++; $display("FAIL contention_grant cyc=%0d got=%b%b exp=%b%b", i, bus.a_ready, bus.b_ready, i != 4, i == 4); end
      tick();
      total++; if (bus.rf_rd !== (i == 4 ? 5'd5 : 5'd2))
        begin bad++; $display("FAIL contention_rd cyc=%0d got=%0d exp=%0d", i, bus.rf_rd, i == 4 ? 5 : 2); end
    end
    idle();
    tick();
    total++; if ({err, busy_mask} !== 33'd0) begin bad++; $display("FAIL contention_clean got=%b/%h exp=0/0", err, busy_mask); end
  endtask
  task automatic test_scoreboard;
    issue_valid = 1; issue_rd = 7;
    tick();
    idle();
    chk_rs2 = 7;
    #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sb_hazard_set got=%b exp=1", hazard); end
    bus.b_valid = 1; bus.b_rd = 7; bus.b_data = 32'h77;
    #1;
    total++; if ({bus.b_ready, hazard} !== 2'b11) begin bad++; $display("FAIL sb_no_bypass got=%b%b exp=11", bus.b_ready, hazard); end
    tick();
    bus.b_valid = 0;
    #1;
    total++; if ({hazard, busy_mask} !== 33'd0) begin bad++; $display("FAIL sb_clear got=%b/%h exp=0/0", hazard, busy_mask); end
    total++; if ({bus.rf_we, bus.rf_rd, bus.rf_wd} !== {1'b1, 5'd7, 32'h77})
      begin bad++; $display("FAIL sb_b_write got=%b/%0d/%h exp=1/7/77", bus.rf_we, bus.rf_rd, bus.rf_wd); end
    issue_valid = 1; issue_rd = 7;
    tick();
    bus.b_valid = 1; bus.b_rd = 7;
    tick();
    idle();
    total++; if ({busy_mask, err} !== {32'h80, 1'b0}) begin bad++; $display("FAIL sb_reissue got=%h/%b exp=80/0", busy_mask, err); end
    bus.b_valid = 1; bus.b_rd = 7;
    tick();
    idle();
    total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL sb_final got=%h exp=0", busy_mask); end
  endtask
  task automatic test_x0;
    bus.a_valid = 1; bus.a_rd = 0; bus.a_data = 32'hFF;
    #1;
    total++; if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", bus.a_ready); end
    tick();
    idle();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%b exp=0", bus.rf_we); end
    issue_valid = 1; issue_rd = 0;
    tick();
    idle();
    #1;
    total++; if ({busy_mask, hazard, err} !== 34'd0) begin bad++; $display("FAIL x0_issue got=%h/%b/%b exp=0/0/0", busy_mask, hazard, err); end
  endtask
  task automatic test_errors;
    bus.b_valid = 1; bus.b_rd = 9;
    tick();
    idle();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_b_not_busy got=%b exp=1", err); end
    tick(); tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_reset got=%b exp=0", err); end
    issue_valid = 1; issue_rd = 12;
    tick();
    idle();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_before_waw got=%b exp=0", err); end
    bus.a_valid = 1; bus.a_rd = 12;
    tick();
    idle();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_waw got=%b exp=1", err); end
    do_reset();
    issue_valid = 1; issue_rd = 6;
    tick();
    tick();
    idle();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_double_issue got=%b exp=1", err); end
    do_reset();
  endtask
  task automatic test_async_reset;
    issue_valid = 1; issue_rd = 7;
    tick();
    idle();
    bus.a_valid = 1; bus.a_rd = 4; bus.a_data = 32'h44;
    tick();
    total++; if ({bus.rf_we, busy_mask, err} !== {1'b1, 32'h80, 1'b0})
      begin bad++; $display("FAIL arst_pre got=%b/%h/%b exp=1/80/0", bus.rf_we, busy_mask, err); end
    #1;
    rst_n = 0;
    #1;
    total++; if ({bus.rf_we, busy_mask, err} !== 34'd0)
      begin bad++; $display("FAIL arst_clear got=%b/%h/%b exp=0/0/0", bus.rf_we, busy_mask, err); end
    idle();
    rst_n = 1;
    tick();
  endtask
  initial begin
    idle();
    rst_n = 1;
    test_reset();
    test_a_only();
    test_contention();
    test_scoreboard();
    test_x0();
    test_errors();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
